// File: rtl/data_bus_ctrl_v2.sv
// data_bus_ctrl_v2
//   Data-memory bus controller between the load/store unit and on-chip RAM.
//   One request in flight at a time. Each access runs through a valid/ready
//   request channel, an optional wait-state countdown, and a valid/ready
//   response channel. Stores write only the selected byte lanes; loads are
//   sign- or zero-extended. A small register window holds sticky error flags
//   (write 1 to clear), the address of the last faulting access, and an ID word.
//
//   Optional feature macro: DBC_PERF_CNT_EN adds 32-bit load/store counters
//   at register offsets +0x0C (RD_CNT) and +0x10 (WR_CNT).
//
// Ports
//   clk           clock
//   rst           synchronous reset, active low
//   req_valid     request present
//   req_ready     request accepted this cycle (IDLE and not in reset)
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads zero-extend when 1, sign-extend when 0
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   rsp_valid     response present (RESP state)
//   rsp_ready     consumer takes the response
//   rsp_rdata     extended load data; 0 for stores, errors and outside RESP
//   rsp_err       [0] misaligned / illegal size, [1] unmapped address
//   busy          high whenever the FSM is not IDLE
//   irq_err       OR of the sticky STATUS flags
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | ready for a request; request fields captured on accept
// S_WAIT | wait-state down-counter running, leaves when it reaches 0
// S_RESP | response held stable until rsp_ready

module data_bus_ctrl_v2 #(
    parameter int                 ADDR_W      = 32,
    parameter int                 RAM_WORDS   = 1024,
    parameter logic [ADDR_W-1:0]  RAM_BASE    = ADDR_W'(32'h0000_1000),
    parameter logic [ADDR_W-1:0]  REG_BASE    = ADDR_W'(32'h0000_0F00),
    parameter int                 WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              busy,
    output logic              irq_err
);

    localparam int              IDX_W     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [ADDR_W:0] RAM_SPAN  = (ADDR_W+1)'(RAM_WORDS) << 2;
    localparam logic [ADDR_W:0] REG_SPAN  = (ADDR_W+1)'(32);
    localparam logic [3:0]      WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0]     ID_VALUE  = 32'h4442_4332;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t state, next_state;
    logic   accept, enter_resp;

    logic [3:0]        wait_cnt;
    logic              lat_we, lat_uns;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic [1:0]        status;
    logic [ADDR_W-1:0] err_addr;
    logic [31:0]       rdata_q;
    logic [1:0]        err_q;

    logic [31:0] ram [RAM_WORDS];

`ifdef DBC_PERF_CNT_EN
    logic [31:0] rd_cnt, wr_cnt;
`endif

    // With zero wait states the access resolves on the accept edge, before
    // the request fields are latched, so decode works on the live request in
    // IDLE and on the latched copy otherwise.
    logic              a_we, a_uns;
    logic [1:0]        a_size;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;

    assign a_we    = (state == S_IDLE) ? req_we       : lat_we;
    assign a_uns   = (state == S_IDLE) ? req_unsigned : lat_uns;
    assign a_size  = (state == S_IDLE) ? req_size     : lat_size;
    assign a_addr  = (state == S_IDLE) ? req_addr     : lat_addr;
    assign a_wdata = (state == S_IDLE) ? req_wdata    : lat_wdata;

    logic [ADDR_W-1:0] ram_off, reg_off;
    logic              in_ram, in_reg, misaligned;
    logic [1:0]        a_err;
    logic [IDX_W-1:0]  ram_idx;
    logic [2:0]        reg_sel;

    always_comb begin
        ram_off    = a_addr - RAM_BASE;
        reg_off    = a_addr - REG_BASE;
        in_ram     = (a_addr >= RAM_BASE) && ({1'b0, ram_off} < RAM_SPAN);
        in_reg     = (a_addr >= REG_BASE) && ({1'b0, reg_off} < REG_SPAN);
        misaligned = (a_size == 2'b11)
                  || (a_size == 2'b01 && a_addr[0])
                  || (a_size == 2'b10 && a_addr[1:0] != 2'b00);
        ram_idx    = ram_off[IDX_W+1:2];
        reg_sel    = reg_off[4:2];
        // err code bit positions match the STATUS flag positions
        a_err = 2'b00;
        if (misaligned)
            a_err = 2'b01;
        else if (!in_ram && !in_reg)
            a_err = 2'b10;
        else if (!in_ram && a_size != 2'b10)
            a_err = 2'b01;
    end

    logic [31:0] reg_word, raw_word, shifted, ld_data;

    always_comb begin
        reg_word = '0;
        case (reg_sel)
            3'd0:    reg_word = {30'd0, status};
            3'd1:    reg_word = 32'(err_addr);
            3'd2:    reg_word = ID_VALUE;
`ifdef DBC_PERF_CNT_EN
            3'd3:    reg_word = rd_cnt;
            3'd4:    reg_word = wr_cnt;
`endif
            default: reg_word = '0;
        endcase
        raw_word = in_ram ? ram[ram_idx] : reg_word;
        shifted  = raw_word >> {a_addr[1:0], 3'b000};
        case (a_size)
            2'b00:   ld_data = a_uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ld_data = a_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
        if (a_we || a_err != 2'b00)
            ld_data = '0;
    end

    logic [3:0]  wmask;
    logic [31:0] wlanes;
    logic        ram_wr;

    always_comb begin
        wmask  = 4'b1111;
        wlanes = a_wdata;
        case (a_size)
            2'b00: begin
                wmask  = 4'b0001 << a_addr[1:0];
                wlanes = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                wmask  = a_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{a_wdata[15:0]}};
            end
            default: begin
                wmask  = 4'b1111;
                wlanes = a_wdata;
            end
        endcase
        ram_wr = a_we && (a_err == 2'b00) && in_ram;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        req_ready  = rst && (state == S_IDLE);
        rsp_valid  = (state == S_RESP);
        busy       = (state != S_IDLE);
        irq_err    = |status;
        rsp_rdata  = rdata_q;
        rsp_err    = err_q;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        next_state = S_WAIT;
                    end else begin
                        next_state = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= '0;
            status    <= '0;
            err_addr  <= '0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_uns   <= req_unsigned;
                lat_size  <= req_size;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                wait_cnt  <= WAIT_LOAD;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (enter_resp) begin
                rdata_q <= ld_data;
                err_q   <= a_err;
                if (a_err != 2'b00) begin
                    status   <= status | a_err;
                    err_addr <= a_addr;
                end else if (a_we && !in_ram && reg_sel == 3'd0) begin
                    status <= status & ~a_wdata[1:0];
                end
            end else if (state == S_RESP && rsp_ready) begin
                rdata_q <= '0;
                err_q   <= '0;
            end
        end
    end

    // RAM has no reset; the rst gate keeps a store that is cut off by reset
    // from committing.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i])
                    ram[ram_idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

`ifdef DBC_PERF_CNT_EN
    // A store that clears a counter is itself not counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (enter_resp && a_err == 2'b00) begin
            if (!a_we)
                rd_cnt <= rd_cnt + 32'd1;
            else if (!in_ram && reg_sel == 3'd3)
                rd_cnt <= '0;
            else if (!in_ram && reg_sel == 3'd4)
                wr_cnt <= '0;
            else
                wr_cnt <= wr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_bus_ctrl_v2.sv
// Bench for data_bus_ctrl_v2: instance 0 runs with no wait states and takes
// the directed vector table; instance 1 runs with three wait states for the
// latency, back-pressure and mid-access reset sequences.
module tb_data_bus_ctrl_v2;

    localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_X = 2'd3;
    localparam logic [31:0] RB = 32'h0000_1000;
    localparam logic [31:0] GB = 32'h0000_0F00;
`ifdef DBC_PERF_CNT_EN
    localparam logic [31:0] EXP_RDCNT = 32'd3;
`else
    localparam logic [31:0] EXP_RDCNT = 32'd0;
`endif

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, busy, irq;
    logic        req_we, req_uns;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] rsp_rdata [2];
    logic [1:0]  rsp_err [2];

    int total = 0;
    int bad = 0;
    int lat [2] = '{0, 3};

    always #5 clk = ~clk;

    data_bus_ctrl_v2 #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_uns), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]), .irq_err(irq[0])
    );

    data_bus_ctrl_v2 #(.WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_uns), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]), .irq_err(irq[1])
    );

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  err;
        logic        irq;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input logic [1:0] e, input logic ir);
        vec_t t;
        t.we = we; t.size = sz; t.uns = uns; t.addr = a; t.wdata = wd;
        t.rdata = rd; t.err = e; t.irq = ir;
        tbl.push_back(t);
    endtask

    // One complete access on instance d; inputs change and outputs are
    // sampled on the falling edge.
    task automatic acc(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic [1:0] e);
        int n;
        rd = 'x;
        e  = 'x;
        @(negedge clk);
        req_we = we; req_size = sz; req_uns = uns; req_addr = a; req_wdata = wd;
        req_valid[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            chk($sformatf("dut%0d req_ready timeout", d), 32'(req_ready[d]), 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
        n = 0;
        while (!rsp_valid[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("dut%0d latency", d), 32'(n), 32'(lat[d]));
        rd = rsp_rdata[d];
        e  = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk($sformatf("dut%0d rdata after take", d), rsp_rdata[d], 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  e;

        rst = 2'b00; req_valid = 2'b00; rsp_ready = 2'b00;
        req_we = 1'b0; req_size = SZ_W; req_uns = 1'b0; req_addr = '0; req_wdata = '0;

        //    we    size  uns   addr           wdata          rdata          err    irq
        add(1'b1, SZ_W, 1'b0, RB,           32'hDEAD_BEEF, 32'h0,         2'b00, 1'b0);
        add(1'b0, SZ_B, 1'b0, RB + 3,       32'h0,         32'hFFFF_FFDE, 2'b00, 1'b0);
        add(1'b1, SZ_B, 1'b0, RB + 2,       32'h0000_005A, 32'h0,         2'b00, 1'b0);
        add(1'b0, SZ_W, 1'b0, RB,           32'h0,         32'hDE5A_BEEF, 2'b00, 1'b0);
        add(1'b0, SZ_H, 1'b1, RB + 2,       32'h0,         32'h0000_DE5A, 2'b00, 1'b0);
        add(1'b0, SZ_H, 1'b0, RB + 2,       32'h0,         32'hFFFF_DE5A, 2'b00, 1'b0);
        add(1'b0, SZ_B, 1'b1, RB + 1,       32'h0,         32'h0000_00BE, 2'b00, 1'b0);
        add(1'b0, SZ_B, 1'b0, RB,           32'h0,         32'hFFFF_FFEF, 2'b00, 1'b0);
        add(1'b0, SZ_W, 1'b0, RB + 2,       32'h0,         32'h0,         2'b01, 1'b1);
        add(1'b0, SZ_W, 1'b0, GB + 4,       32'h0,         RB + 2,        2'b00, 1'b1);
        add(1'b0, SZ_W, 1'b0, GB,           32'h0,         32'h1,         2'b00, 1'b1);
        add(1'b1, SZ_W, 1'b0, GB,           32'h1,         32'h0,         2'b00, 1'b0);
        add(1'b0, SZ_W, 1'b0, GB,           32'h0,         32'h0,         2'b00, 1'b0);
        add(1'b0, SZ_W, 1'b0, 32'hFFFF_0000, 32'h0,        32'h0,         2'b10, 1'b1);
        add(1'b0, SZ_W, 1'b0, GB + 4,       32'h0,         32'hFFFF_0000, 2'b00, 1'b1);
        add(1'b0, SZ_W, 1'b0, GB,           32'h0,         32'h2,         2'b00, 1'b1);
        add(1'b0, SZ_H, 1'b0, GB + 8,       32'h0,         32'h0,         2'b01, 1'b1);
        add(1'b0, SZ_W, 1'b0, GB,           32'h0,         32'h3,         2'b00, 1'b1);
        add(1'b1, SZ_W, 1'b0, GB,           32'h3,         32'h0,         2'b00, 1'b0);
        add(1'b0, SZ_W, 1'b0, GB + 8,       32'h0,         32'h4442_4332, 2'b00, 1'b0);
        add(1'b0, SZ_W, 1'b0, RB,           32'h0,         32'hDE5A_BEEF, 2'b00, 1'b0);
        add(1'b0, SZ_X, 1'b0, RB,           32'h0,         32'h0,         2'b01, 1'b1);
        add(1'b1, SZ_W, 1'b0, GB + 4,       32'h1234_5678, 32'h0,         2'b00, 1'b1);
        add(1'b0, SZ_W, 1'b0, GB + 4,       32'h0,         RB,            2'b00, 1'b1);
        add(1'b1, SZ_W, 1'b0, GB,           32'h1,         32'h0,         2'b00, 1'b0);
        add(1'b1, SZ_W, 1'b0, RB + 4,       32'h1122_3344, 32'h0,         2'b00, 1'b0);
        add(1'b1, SZ_H, 1'b0, RB + 6,       32'hA5A5_CAFE, 32'h0,         2'b00, 1'b0);
        add(1'b0, SZ_W, 1'b0, RB + 4,       32'h0,         32'hCAFE_3344, 2'b00, 1'b0);
        add(1'b0, SZ_W, 1'b0, GB + 32'h1C,  32'h0,         32'h0,         2'b00, 1'b0);
        add(1'b0, SZ_W, 1'b0, GB + 32'h20,  32'h0,         32'h0,         2'b10, 1'b1);
        add(1'b1, SZ_W, 1'b0, RB + 32'hFFC, 32'h0BAD_F00D, 32'h0,         2'b00, 1'b1);
        add(1'b0, SZ_W, 1'b0, RB + 32'hFFC, 32'h0,         32'h0BAD_F00D, 2'b00, 1'b1);
        add(1'b0, SZ_W, 1'b0, RB + 32'h1000, 32'h0,        32'h0,         2'b10, 1'b1);
        add(1'b1, SZ_W, 1'b0, GB,           32'h2,         32'h0,         2'b00, 1'b0);
        add(1'b1, SZ_B, 1'b0, GB,           32'hFF,        32'h0,         2'b01, 1'b1);
        add(1'b0, SZ_W, 1'b0, GB,           32'h0,         32'h1,         2'b00, 1'b1);
        add(1'b1, SZ_W, 1'b0, GB,           32'hFFFF_FFFF, 32'h0,         2'b00, 1'b0);
        add(1'b1, SZ_W, 1'b0, RB + 1,       32'h9999_9999, 32'h0,         2'b01, 1'b1);
        add(1'b0, SZ_W, 1'b0, RB,           32'h0,         32'hDE5A_BEEF, 2'b00, 1'b1);
        add(1'b1, SZ_W, 1'b0, GB,           32'h1,         32'h0,         2'b00, 1'b0);
        add(1'b0, SZ_H, 1'b0, RB + 1,       32'h0,         32'h0,         2'b01, 1'b1);
        add(1'b1, SZ_W, 1'b0, GB,           32'h1,         32'h0,         2'b00, 1'b0);

        // reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d reset req_ready", d), 32'(req_ready[d]), 32'd0);
            chk($sformatf("dut%0d reset busy", d),      32'(busy[d]),      32'd0);
            chk($sformatf("dut%0d reset rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("dut%0d reset rdata", d),     rsp_rdata[d],      32'd0);
            chk($sformatf("dut%0d reset err", d),       32'(rsp_err[d]),   32'd0);
            chk($sformatf("dut%0d reset irq", d),       32'(irq[d]),       32'd0);
        end
        rst = 2'b11;
        @(negedge clk);
        chk("dut0 req_ready after reset", 32'(req_ready[0]), 32'd1);

        // directed vectors on the zero-wait instance
        for (int i = 0; i < tbl.size(); i++) begin
            acc(0, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, e);
            chk($sformatf("v%0d rdata", i), rd,          tbl[i].rdata);
            chk($sformatf("v%0d err", i),   32'(e),      32'(tbl[i].err));
            chk($sformatf("v%0d irq", i),   32'(irq[0]), 32'(tbl[i].irq));
        end

        // three wait states, response back-pressured for five cycles
        acc(1, 1'b1, SZ_W, 1'b0, RB + 32'h10, 32'hA5A5_A5A5, rd, e);
        @(negedge clk);
        req_we = 1'b0; req_size = SZ_W; req_uns = 1'b0; req_addr = RB + 32'h10;
        req_valid[1] = 1'b1;
        chk("w3 ready at accept", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("w3 valid early c%0d", c), 32'(rsp_valid[1]), 32'd0);
            chk($sformatf("w3 ready in wait c%0d", c), 32'(req_ready[1]), 32'd0);
            @(negedge clk);
        end
        chk("w3 valid at k+4", 32'(rsp_valid[1]), 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("w3 held rdata c%0d", c), rsp_rdata[1], 32'hA5A5_A5A5);
            chk($sformatf("w3 held valid c%0d", c), 32'(rsp_valid[1]), 32'd1);
            chk($sformatf("w3 ready in resp c%0d", c), 32'(req_ready[1]), 32'd0);
            @(negedge clk);
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        rsp_ready[1] = 1'b0;
        chk("w3 valid after take", 32'(rsp_valid[1]), 32'd0);
        chk("w3 rdata after take", rsp_rdata[1], 32'd0);

        // reset in the middle of a waiting store
        @(negedge clk);
        req_we = 1'b1; req_size = SZ_W; req_addr = RB + 32'h10; req_wdata = 32'h1234_5678;
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("w3 busy in wait", 32'(busy[1]), 32'd1);
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        chk("w3 mid reset busy",      32'(busy[1]),      32'd0);
        chk("w3 mid reset rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("w3 mid reset req_ready", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        rst[1] = 1'b1;
        repeat (5) @(negedge clk);
        chk("w3 no late response", 32'(rsp_valid[1]), 32'd0);
        acc(1, 1'b0, SZ_W, 1'b0, RB + 32'h10, 32'h0, rd, e);
        chk("w3 word unchanged", rd, 32'hA5A5_A5A5);

        // load counter: cleared by a store, three loads, then a reset
        acc(0, 1'b1, SZ_W, 1'b0, GB + 32'hC, 32'h0, rd, e);
        chk("rdcnt clear err", 32'(e), 32'd0);
        for (int j = 0; j < 3; j++)
            acc(0, 1'b0, SZ_W, 1'b0, RB, 32'h0, rd, e);
        acc(0, 1'b0, SZ_W, 1'b0, GB + 32'hC, 32'h0, rd, e);
        chk("rdcnt after 3 loads", rd, EXP_RDCNT);
        @(negedge clk);
        rst[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst[0] = 1'b1;
        acc(0, 1'b0, SZ_W, 1'b0, GB + 32'hC, 32'h0, rd, e);
        chk("rdcnt after reset", rd, 32'd0);
        acc(0, 1'b0, SZ_W, 1'b0, GB, 32'h0, rd, e);
        chk("status after reset", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
